// File: rtl/frame_interleaver_pkg.sv
// Shared interleaver geometry and bank helpers; the de-interleaver imports the same defaults.
package frame_interleaver_pkg;

  localparam int unsigned CODEWORD_SIZE_IN_32 = 65;
  localparam int unsigned NUM_CODEWORDS       = 4;
  localparam int unsigned FRAME_WORDS         = CODEWORD_SIZE_IN_32 * NUM_CODEWORDS;
  localparam int unsigned BANK_ADDR_W         = $clog2(2 * FRAME_WORDS);

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_t;

  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

  function automatic int unsigned bank_base(input bank_t b, input int unsigned frame_words);
    return (b == BANK_1) ? frame_words : 0;
  endfunction

endpackage

// File: rtl/interleave_bank_ram.sv
// Simple dual-port frame store: one write port, one registered read port with read enable.
module interleave_bank_ram
  import frame_interleaver_pkg::*;
#(
  parameter int unsigned DEPTH = 2 * FRAME_WORDS,
  parameter int unsigned AW    = BANK_ADDR_W,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the output data register, so it holds when re is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_interleaver.sv
// Ping-pong block interleaver: channel-order words in, codeword-order words out.
module frame_interleaver
  import frame_interleaver_pkg::*;
#(
  parameter int unsigned CODEWORD_SIZE_IN_32 = frame_interleaver_pkg::CODEWORD_SIZE_IN_32,
  parameter int unsigned NUM_CODEWORDS       = frame_interleaver_pkg::NUM_CODEWORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_err
);

  localparam int unsigned CW    = CODEWORD_SIZE_IN_32;
  localparam int unsigned NC    = NUM_CODEWORDS;
  localparam int unsigned FW    = CW * NC;
  localparam int unsigned AW    = $clog2(2 * FW);
  localparam int unsigned RW    = (CW > 1) ? $clog2(CW) : 1;
  localparam int unsigned CWIDX = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned MW    = (FW > 1) ? $clog2(FW) : 1;

  bank_t            wbank;
  bank_t            rbank;
  logic [1:0]       full;
  logic [CWIDX-1:0] wcol;
  logic [RW-1:0]    wrow;
  logic [MW-1:0]    rcnt;

  logic          s_fire;
  logic          wr_last;
  logic          rd_issue;
  logic          rd_last;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign s_axis_tready = !full[wbank];
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign wr_last       = (wcol == CWIDX'(NC - 1)) && (wrow == RW'(CW - 1));
  assign rd_issue      = full[rbank] && (!m_axis_tvalid || m_axis_tready);
  assign rd_last       = (rcnt == MW'(FW - 1));

  // Column-major store, row-major drain; constant multipliers only, no divider.
  assign wr_addr = AW'(bank_base(wbank, FW) + 32'(wcol) * CW + 32'(wrow));
  assign rd_addr = AW'(bank_base(rbank, FW) + 32'(rcnt));

  interleave_bank_ram #(
    .DEPTH (2 * FW),
    .AW    (AW),
    .DW    (32)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (s_fire),
    .waddr (wr_addr),
    .wdata (s_axis_tdata),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (m_axis_tdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank         <= BANK_0;
      rbank         <= BANK_0;
      full          <= '0;
      wcol          <= '0;
      wrow          <= '0;
      rcnt          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_err <= s_fire && (s_axis_tlast != wr_last);

      if (s_fire) begin
        if (wcol == CWIDX'(NC - 1)) begin
          wcol <= '0;
          wrow <= wr_last ? '0 : wrow + 1'b1;
        end else begin
          wcol <= wcol + 1'b1;
        end
        if (wr_last) begin
          full[wbank] <= 1'b1;
          wbank       <= other_bank(wbank);
        end
      end

      // Set and clear never target the same bank: a bank being written is never full.
      if (rd_issue) begin
        rcnt          <= rd_last ? '0 : rcnt + 1'b1;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= rd_last;
        if (rd_last) begin
          full[rbank] <= 1'b0;
          rbank       <= other_bank(rbank);
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_interleaver.sv
// Scoreboard bench for frame_interleaver: table-driven traffic runs plus reset, latency and backpressure sequences.
module tb_frame_interleaver;

  localparam int CW = 65;
  localparam int N  = 4;
  localparam int F  = CW * N;

  logic        clk;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        frame_err;

  frame_interleaver #(
    .CODEWORD_SIZE_IN_32 (CW),
    .NUM_CODEWORDS       (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int vld_pct;
    int rdy_pct;
    int frames;
    bit rand_data;
    bit bad_tlast;
    int exp_words;
    int exp_errs;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] in_buf [F];

  int checks = 0;
  int failures = 0;

  int vld_pct = 0;
  int rdy_pct = 100;
  bit rand_data = 1'b0;
  bit bad_tlast = 1'b0;
  int frames_sent = 0;
  int frames_target = 0;
  int drv_k = 0;
  bit in_fire = 1'b0;

  int mon_k = 0;
  bit err_pend = 1'b0;
  bit stall_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  int ncyc = 0;
  int out_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;
  int rdy_low_cnt = 0;
  int first_out_n = -1;
  int last_out_n = 0;
  int last_in_n = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Input driver: holds a word until accepted, stops after frames_target frames.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      drv_k = 0;
    end else begin
      if (in_fire) begin
        if (drv_k == F - 1) begin
          drv_k = 0;
          frames_sent++;
        end else begin
          drv_k++;
        end
        s_axis_tvalid = 1'b0;
      end
      if (!s_axis_tvalid && frames_sent < frames_target && int'($urandom_range(99)) < vld_pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_data ? $urandom : 32'(drv_k);
        s_axis_tlast  = bad_tlast ? (drv_k == 100) : (drv_k == F - 1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      sb.delete();
      mon_k = 0;
      in_fire = 1'b0;
      err_pend = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("frame_err", frame_err, err_pend);
      if (frame_err) err_cnt++;
      if (stall_prev) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, hold_data);
        check("hold_last", m_axis_tlast, hold_last);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_data  = m_axis_tdata;
      hold_last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("out_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_last", m_axis_tlast, e.last);
        end
        out_cnt++;
        if (first_out_n < 0) first_out_n = ncyc;
        last_out_n = ncyc;
      end
      if (s_axis_tvalid && !s_axis_tready) rdy_low_cnt++;
      in_fire = s_axis_tvalid && s_axis_tready;
      if (in_fire) begin
        acc_cnt++;
        in_buf[mon_k] = s_axis_tdata;
        err_pend = (s_axis_tlast != (mon_k == F - 1));
        if (mon_k == F - 1) begin
          // Output m is codeword m/CW, index m%CW, i.e. input word (m%CW)*N + m/CW.
          for (int m = 0; m < F; m++) begin
            e.data = in_buf[(m % CW) * N + m / CW];
            e.last = (m == F - 1);
            sb.push_back(e);
          end
          mon_k = 0;
          last_in_n = ncyc;
        end else begin
          mon_k++;
        end
      end else begin
        err_pend = 1'b0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    vld_pct = v.vld_pct;
    rdy_pct = v.rdy_pct;
    rand_data = v.rand_data;
    bad_tlast = v.bad_tlast;
    out_cnt = 0;
    err_cnt = 0;
    rdy_low_cnt = 0;
    first_out_n = -1;
    frames_target = frames_sent + v.frames;
    n = 0;
    while ((out_cnt < v.exp_words || frames_sent < frames_target) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("words_out", out_cnt, v.exp_words);
    check("frame_err_pulses", err_cnt, v.exp_errs);
    check("sb_empty", sb.size(), 0);
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{100, 100, 1,  1'b0, 1'b0, F,      0};
    vecs[1] = '{100, 100, 1,  1'b0, 1'b1, F,      2};
    vecs[2] = '{100, 100, 3,  1'b1, 1'b0, 3 * F,  0};
    vecs[3] = '{50,  50,  20, 1'b1, 1'b0, 20 * F, 0};
    vecs[4] = '{70,  30,  2,  1'b1, 1'b0, 2 * F,  0};

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", s_axis_tready, 1);

    // Idle DUT: last input accepted at T, first output valid at T+2.
    run_vec(vecs[0]);
    check("latency", first_out_n - last_in_n, 2);

    // Back-to-back frames with no bubbles on either side.
    run_vec(vecs[2]);
    check("contig_span", last_out_n - first_out_n + 1, 3 * F);
    check("s_tready_drops", rdy_low_cnt, 0);

    // Downstream stalled: both banks fill, then drain in order on release.
    vld_pct = 100;
    rdy_pct = 0;
    rand_data = 1'b1;
    bad_tlast = 1'b0;
    out_cnt = 0;
    acc_cnt = 0;
    frames_target = frames_sent + 3;
    repeat (700) @(negedge clk);
    check("bp_accepts", acc_cnt, 2 * F);
    check("bp_s_tready", s_axis_tready, 0);
    check("bp_m_tvalid", m_axis_tvalid, 1);
    check("bp_m_tdata", m_axis_tdata, sb[0].data);
    check("bp_out_cnt", out_cnt, 0);
    rdy_pct = 100;
    n = 0;
    while ((out_cnt < 3 * F || frames_sent < frames_target) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("bp_drain_words", out_cnt, 3 * F);
    check("bp_sb_empty", sb.size(), 0);

    // Reset partway through a frame, then one clean frame.
    vld_pct = 100;
    rdy_pct = 100;
    rand_data = 1'b0;
    out_cnt = 0;
    frames_target = frames_sent + 1;
    n = 0;
    while (mon_k != 130 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reached", mon_k, 130);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_m_tvalid", m_axis_tvalid, 0);
    check("mid_rst_m_tdata", m_axis_tdata, 0);
    check("mid_rst_m_tlast", m_axis_tlast, 0);
    check("mid_rst_frame_err", frame_err, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_s_tready", s_axis_tready, 1);
    n = 0;
    while ((out_cnt < F || frames_sent < frames_target) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("mid_rst_words", out_cnt, F);
    check("mid_rst_sb_empty", sb.size(), 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
